// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use and branch-operand stalls, IF/ID flush, ID/EX bubble, memory-wait freeze and halt.
// Optional statistics counters are compiled in when HAZARD_STATS_EN is defined.
module hazard_controller #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_use_rs,
    input  logic       ID_use_rt,
    input  logic       ID_branch,
    input  logic [4:0] EX_RW,
    input  logic       EX_regwe,
    input  logic       EX_memread,
    input  logic [4:0] MEM_RW,
    input  logic       MEM_memread,
    input  logic       branch_taken,
    input  logic       mem_busy,
    input  logic       halt,
    input  logic       resume,
    output logic       PC_en,
    output logic       IF_ID_en,
    output logic       ID_EX_en,
    output logic       EX_MEM_en,
    output logic       MEM_WB_en,
    output logic       IF_ID_flush,
    output logic       ID_EX_flush,
`ifdef HAZARD_STATS_EN
    output logic       halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count
`else
    output logic       halted
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t     state_r, state_nxt_s;
    logic [1:0] scnt_r, scnt_nxt_s;
    logic [1:0] haz_n_s;
    logic       ex_match_s, mem_match_s, stalling_s;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("hazard_controller: CNT_W must be at least 1");
    end

    // A register 0 destination never creates a dependency.
    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic use_rs, input logic use_rt);
        return (r != 5'd0) && ((use_rs && (rs == r)) || (use_rt && (rt == r)));
    endfunction

    // Hazard classification: number of stall cycles this ID instruction needs, first match wins.
    always_comb begin
        ex_match_s  = reg_match(EX_RW, ID_rs, ID_rt, ID_use_rs, ID_use_rt);
        mem_match_s = reg_match(MEM_RW, ID_rs, ID_rt, ID_use_rs, ID_use_rt);
        if (ID_branch && EX_memread && ex_match_s) begin
            haz_n_s = 2'd2;
        end else if (ID_branch && EX_regwe && ex_match_s) begin
            haz_n_s = 2'd1;
        end else if (ID_branch && MEM_memread && mem_match_s) begin
            haz_n_s = 2'd1;
        end else if (EX_memread && ex_match_s) begin
            haz_n_s = 2'd1;
        end else begin
            haz_n_s = 2'd0;
        end
    end

    // Next-state and output decode; reset forces the safe output pattern.
    always_comb begin
        state_nxt_s = state_r;
        scnt_nxt_s  = scnt_r;
        stalling_s  = 1'b0;
        PC_en       = 1'b0;
        IF_ID_en    = 1'b0;
        ID_EX_en    = 1'b0;
        EX_MEM_en   = 1'b0;
        MEM_WB_en   = 1'b0;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        halted      = 1'b0;
        case (state_r)
            HALT: begin
                halted = 1'b1;
                if (halt) begin
                    state_nxt_s = HALT;
                end else if (resume) begin
                    state_nxt_s = RUN;
                    scnt_nxt_s  = 2'd0;
                end else begin
                    state_nxt_s = HALT;
                end
            end
            RUN, STALL: begin
                // STALL with an exhausted counter re-evaluates as RUN.
                stalling_s = ((state_r == STALL) && (scnt_r != 2'd0)) || (haz_n_s != 2'd0);
                if (halt) begin
                    state_nxt_s = HALT;
                end else if (mem_busy) begin
                    state_nxt_s = state_r;
                end else if ((state_r == STALL) && (scnt_r != 2'd0)) begin
                    scnt_nxt_s  = scnt_r - 2'd1;
                    state_nxt_s = (scnt_r == 2'd1) ? RUN : STALL;
                end else if (haz_n_s == 2'd2) begin
                    state_nxt_s = STALL;
                    scnt_nxt_s  = 2'd1;
                end else begin
                    state_nxt_s = RUN;
                end
                if (mem_busy) begin
                    PC_en = 1'b0;
                end else if (stalling_s) begin
                    ID_EX_en    = 1'b1;
                    EX_MEM_en   = 1'b1;
                    MEM_WB_en   = 1'b1;
                    ID_EX_flush = 1'b1;
                end else begin
                    PC_en       = 1'b1;
                    IF_ID_en    = 1'b1;
                    ID_EX_en    = 1'b1;
                    EX_MEM_en   = 1'b1;
                    MEM_WB_en   = 1'b1;
                    IF_ID_flush = branch_taken;
                end
            end
            default: begin
                state_nxt_s = RUN;
                scnt_nxt_s  = 2'd0;
            end
        endcase
        if (!rst_n) begin
            PC_en       = 1'b0;
            IF_ID_en    = 1'b0;
            ID_EX_en    = 1'b0;
            EX_MEM_en   = 1'b0;
            MEM_WB_en   = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            halted      = 1'b0;
        end else begin
            halted = halted;
        end
    end

    // State and stall-counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= RUN;
            scnt_r  <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            scnt_r  <= scnt_nxt_s;
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating event counters; reset cycles are not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            if (!PC_en && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (ID_EX_flush && (bubble_count != CNT_MAX)) begin
                bubble_count <= bubble_count + CNT_ONE;
            end
            if (IF_ID_flush && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scenarios followed by randomized traffic, checked against a cycle-level reference model.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ID_rs, ID_rt, EX_RW, MEM_RW;
    logic       ID_use_rs, ID_use_rt, ID_branch, EX_regwe, EX_memread, MEM_memread;
    logic       branch_taken, mem_busy, halt, resume;
    logic       PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush, halted;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, bubble_count, flush_count;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state: halted flag and number of extra stall cycles still owed.
    bit  m_halted = 1'b0;
    int  m_extra  = 0;
    int  m_stall = 0, m_bubble = 0, m_flush = 0;

    always #5 clk = ~clk;

    hazard_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
        .ID_branch(ID_branch), .EX_RW(EX_RW), .EX_regwe(EX_regwe), .EX_memread(EX_memread),
        .MEM_RW(MEM_RW), .MEM_memread(MEM_memread), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .halt(halt), .resume(resume),
        .PC_en(PC_en), .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en), .EX_MEM_en(EX_MEM_en),
        .MEM_WB_en(MEM_WB_en), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
`ifdef HAZARD_STATS_EN
        .halted(halted),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count), .flush_count(flush_count)
`else
        .halted(halted)
`endif
    );

    function automatic bit depends_on(input logic [4:0] r);
        return (r != 5'd0) && ((ID_use_rs && ID_rs == r) || (ID_use_rt && ID_rt == r));
    endfunction

    function automatic int hazard_cycles();
        if (ID_branch && EX_memread && depends_on(EX_RW)) return 2;
        if (ID_branch && EX_regwe && depends_on(EX_RW)) return 1;
        if (ID_branch && MEM_memread && depends_on(MEM_RW)) return 1;
        if (EX_memread && depends_on(EX_RW)) return 1;
        return 0;
    endfunction

    // Expected {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush, halted}
    function automatic logic [7:0] model_out();
        if (!rst_n) return 8'b00000_11_0;
        if (m_halted) return 8'b00000_00_1;
        if (mem_busy) return 8'b00000_00_0;
        if (m_extra > 0 || hazard_cycles() > 0) return 8'b00111_01_0;
        return {5'b11111, branch_taken, 2'b00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_use_rs = 1'b0; ID_use_rt = 1'b0; ID_branch = 1'b0;
        EX_RW = 5'd0; EX_regwe = 1'b0; EX_memread = 1'b0; MEM_RW = 5'd0; MEM_memread = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0; halt = 1'b0; resume = 1'b0;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model across the edge.
    task automatic step(input string tag, input bit use_lit, input logic [7:0] lit);
        logic [7:0] obs, exp;
        int n;
        @(negedge clk);
        obs = {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush, halted};
        exp = model_out();
        n   = hazard_cycles();
        check(tag, {24'd0, obs}, {24'd0, use_lit ? lit : exp});
`ifdef HAZARD_STATS_EN
        check({tag, "_stall_cnt"}, stall_cycles, m_stall);
        check({tag, "_bubble_cnt"}, bubble_count, m_bubble);
        check({tag, "_flush_cnt"}, flush_count, m_flush);
`endif
        @(posedge clk);
        if (!rst_n) begin
            m_stall = 0; m_bubble = 0; m_flush = 0;
        end else begin
            m_stall  += (exp[7] == 1'b0) ? 1 : 0;
            m_bubble += exp[1] ? 1 : 0;
            m_flush  += exp[2] ? 1 : 0;
        end
        if (!rst_n) begin
            m_halted = 1'b0; m_extra = 0;
        end else if (m_halted) begin
            if (!halt && resume) begin
                m_halted = 1'b0; m_extra = 0;
            end
        end else if (halt) begin
            m_halted = 1'b1;
        end else if (mem_busy) begin
            m_extra = m_extra;
        end else if (m_extra > 0) begin
            m_extra--;
        end else if (n == 2) begin
            m_extra = 1;
        end
        #1;
    endtask

    task automatic load_use_setup(input logic [4:0] r, input bit branch);
        EX_RW = r; EX_regwe = 1'b1; EX_memread = 1'b1;
        ID_rs = r; ID_use_rs = 1'b1; ID_branch = branch;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        step("reset0", 1'b1, 8'b00000_11_0);
        step("reset1", 1'b1, 8'b00000_11_0);
        rst_n = 1'b1;
        step("idle", 1'b1, 8'b11111_00_0);

        load_use_setup(5'd2, 1'b0);
        step("lu_stall", 1'b1, 8'b00111_01_0);
        clear_inputs();
        step("lu_release", 1'b1, 8'b11111_00_0);

        load_use_setup(5'd3, 1'b1);
        step("beq_lw_stall1", 1'b1, 8'b00111_01_0);
        clear_inputs(); ID_branch = 1'b1; ID_rs = 5'd3; ID_use_rs = 1'b1;
        MEM_RW = 5'd3; MEM_memread = 1'b1;
        step("beq_lw_stall2", 1'b1, 8'b00111_01_0);
        MEM_memread = 1'b0; branch_taken = 1'b1;
        step("beq_taken_flush", 1'b1, 8'b11111_10_0);
        clear_inputs();
        step("after_branch", 1'b1, 8'b11111_00_0);

        load_use_setup(5'd0, 1'b1);
        step("reg0_no_stall", 1'b1, 8'b11111_00_0);

        load_use_setup(5'd3, 1'b1);
        step("busy_enter_stall", 1'b1, 8'b00111_01_0);
        EX_memread = 1'b0; EX_regwe = 1'b0; MEM_RW = 5'd3; MEM_memread = 1'b1; mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) step("busy_freeze", 1'b1, 8'b00000_00_0);
        mem_busy = 1'b0;
        step("busy_remaining_stall", 1'b1, 8'b00111_01_0);
        clear_inputs();
        step("busy_back_run", 1'b1, 8'b11111_00_0);

        halt = 1'b1; resume = 1'b1;
        step("halt_and_resume", 1'b1, 8'b11111_00_0);
        halt = 1'b0; resume = 1'b0;
        step("in_halt", 1'b1, 8'b00000_00_1);
        resume = 1'b1;
        step("resume_cycle", 1'b1, 8'b00000_00_1);
        resume = 1'b0;
        step("after_resume", 1'b1, 8'b11111_00_0);
        halt = 1'b1;
        step("halt2", 1'b1, 8'b11111_00_0);
        halt = 1'b0;
        step("in_halt2", 1'b1, 8'b00000_00_1);
        rst_n = 1'b0;
        step("reset_in_halt", 1'b1, 8'b00000_11_0);
        rst_n = 1'b1;
        step("after_reset_halt", 1'b1, 8'b11111_00_0);

        // Three load-use stalls and two taken branches from freshly cleared counters.
        for (int i = 0; i < 3; i++) begin
            load_use_setup(5'd5, 1'b0);
            step("stats_lu", 1'b0, 8'd0);
            clear_inputs();
            step("stats_lu_rel", 1'b0, 8'd0);
        end
        for (int i = 0; i < 2; i++) begin
            branch_taken = 1'b1;
            step("stats_br", 1'b0, 8'd0);
        end
        clear_inputs();
`ifdef HAZARD_STATS_EN
        @(negedge clk);
        check("stats_stall_total", stall_cycles, 32'd3);
        check("stats_bubble_total", bubble_count, 32'd3);
        check("stats_flush_total", flush_count, 32'd2);
        @(posedge clk); #1;
`endif

        for (int i = 0; i < 3000; i++) begin
            ID_rs        = 5'($urandom_range(0, 3));
            ID_rt        = 5'($urandom_range(0, 3));
            ID_use_rs    = 1'($urandom_range(0, 1));
            ID_use_rt    = 1'($urandom_range(0, 1));
            ID_branch    = ($urandom_range(0, 2) == 0);
            EX_RW        = 5'($urandom_range(0, 3));
            EX_regwe     = 1'($urandom_range(0, 1));
            EX_memread   = ($urandom_range(0, 2) == 0);
            MEM_RW       = 5'($urandom_range(0, 3));
            MEM_memread  = ($urandom_range(0, 2) == 0);
            branch_taken = 1'($urandom_range(0, 1));
            mem_busy     = ($urandom_range(0, 4) == 0);
            halt         = ($urandom_range(0, 24) == 0);
            resume       = ($urandom_range(0, 3) == 0);
            rst_n        = ($urandom_range(0, 59) != 0);
            step("random", 1'b0, 8'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
